// File: rtl/rounder_scheduler.sv
// Round-robin scheduler that time-shares one rounder between NCH requesters.
// It picks one requester per cycle and drives the rounder input. Each result
// comes back one cycle later, tagged with the channel it came from. While a
// result waits for the consumer, no new sample is issued, because the rounder
// holds its output as long as DIN_CE is low.
module rounder_scheduler #(
  parameter int NCH        = 4,
  parameter int DIN_WIDTH  = 12,
  parameter int DOUT_WIDTH = 10,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [NCH*DIN_WIDTH-1:0] REQ_DATA,
  input  logic [NCH-1:0]           REQ_VALID,
  output logic [NCH-1:0]           REQ_READY,
  output logic [DIN_WIDTH-1:0]     RND_DIN,
  output logic                     RND_CE,
  input  logic [DOUT_WIDTH-1:0]    RND_DOUT,
  output logic [DOUT_WIDTH-1:0]    RES_DATA,
  output logic [CW-1:0]            RES_CH,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic                     BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   cand;
  logic            any_valid;
  logic            issue;
  logic            res_valid;
  logic [CW-1:0]   res_ch;

  // Adds an offset to a channel index, wrapping at NCH (works for non-power-of-2 NCH).
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NCH) sum = sum - NCH;
    return CW'(sum);
  endfunction

  // Pick the first valid channel starting at ptr; lower offsets win, so scan high to low.
  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = |REQ_VALID;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = wrap_add(ptr, k);
      if (REQ_VALID[cand]) grant = cand;
    end
  end

  // Issue only when running, enabled, something is requested and the result slot frees up.
  always_comb begin
    issue     = !RST && (state == ACTIVE) && EN && any_valid && (!res_valid || RES_READY);
    REQ_READY = issue ? (NCH'(1) << grant) : '0;
    RND_CE    = issue;
    RND_DIN   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (any_valid && (grant == CW'(i))) RND_DIN = REQ_DATA[i*DIN_WIDTH +: DIN_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: DRAIN lets a pending result leave before stopping.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (EN) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!EN) state_next = res_valid ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (res_valid && RES_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer, result tag and result-valid flag; a new issue overrides a consumed result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr       <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
    end else if (issue) begin
      ptr       <= wrap_add(grant, 1);
      res_ch    <= grant;
      res_valid <= 1'b1;
    end else if (RES_READY) begin
      res_valid <= 1'b0;
    end
  end

  assign RES_DATA  = RND_DOUT;
  assign RES_CH    = res_ch;
  assign RES_VALID = res_valid;
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_rounder_scheduler.sv
// Directed testbench for rounder_scheduler with a behavioural round-toward-zero rounder.
module tb_rounder_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int OW  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]  req_valid;
  logic [NCH-1:0]  req_ready;
  logic [DW-1:0]   rnd_din;
  logic            rnd_ce;
  logic [OW-1:0]   rnd_dout;
  logic [OW-1:0]   res_data;
  logic [1:0]      res_ch;
  logic            res_valid;
  logic            res_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_data [NCH];

  rounder_scheduler #(.NCH(NCH), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)) dut (
    .CLK(clk), .RST(rst), .EN(en), .REQ_DATA(req_data), .REQ_VALID(req_valid),
    .REQ_READY(req_ready), .RND_DIN(rnd_din), .RND_CE(rnd_ce), .RND_DOUT(rnd_dout),
    .RES_DATA(res_data), .RES_CH(res_ch), .RES_VALID(res_valid), .RES_READY(res_ready),
    .BUSY(busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Round-toward-zero by dropping the two LSBs; negative values with a fraction step up by one.
  function automatic logic [OW-1:0] rtz(input logic [DW-1:0] d);
    logic [OW-1:0] q;
    q = d[DW-1:2];
    if (d[DW-1] && (d[1:0] != 2'b00)) q = q + 1'b1;
    return q;
  endfunction

  // Rounder model: one clock latency, output held while DIN_CE is low.
  always @(posedge clk) begin
    if (rnd_ce) rnd_dout <= rtz(rnd_din);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req_data = '0; req_valid = '0; res_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", res_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (res_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_ch: got %0d expected 0", res_ch); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single();
    rst = 1'b0; en = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %0b expected 1", busy); end
    req_data[2*DW +: DW] = 12'h00F; req_valid = 4'b0100; res_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    n_checks++; if (rnd_ce !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ce: got %0b expected 1", rnd_ce); end
    n_checks++; if (rnd_din !== 12'h00F) begin n_fail++; $display("[TB] FAIL single_din: got %h expected 00f", rnd_din); end
    tick();
    req_valid = 4'b0000;
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %0b expected 1", res_valid); end
    n_checks++; if (res_data !== 10'h003) begin n_fail++; $display("[TB] FAIL single_data: got %h expected 003", res_data); end
    n_checks++; if (res_ch !== 2'd2) begin n_fail++; $display("[TB] FAIL single_ch: got %0d expected 2", res_ch); end
    #1;
    n_checks++; if (rnd_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ce_off: got %0b expected 0", rnd_ce); end
    tick();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_consumed: got %0b expected 0", res_valid); end
  endtask

  task automatic test_negative();
    req_data[0 +: DW] = 12'hFF1; req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL neg_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    n_checks++; if (res_data !== 10'h3FD) begin n_fail++; $display("[TB] FAIL neg_data: got %h expected 3fd", res_data); end
    n_checks++; if (res_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL neg_ch: got %0d expected 0", res_ch); end
    tick();
  endtask

  task automatic test_round_robin();
    req_data = {12'hFF0, 12'h30C, 12'h208, 12'h104};
    exp_data[0] = 10'h041; exp_data[1] = 10'h082; exp_data[2] = 10'h0C3; exp_data[3] = 10'h3FC;
    // ptr is 1 here; a lone ch3 request moves it to 0.
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b1111;
    n_checks++; if (res_ch !== 2'd3 || res_data !== 10'h3FC) begin n_fail++; $display("[TB] FAIL rr_prime: got ch %0d data %h expected ch 3 data 3fc", res_ch, res_data); end
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++; if (req_ready !== (4'b0001 << (k % 4))) begin n_fail++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)); end
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_ch !== 2'(k % 4) || res_data !== exp_data[k % 4]) begin
        n_fail++; $display("[TB] FAIL rr_result[%0d]: got v %0b ch %0d data %h expected v 1 ch %0d data %h", k, res_valid, res_ch, res_data, k % 4, exp_data[k % 4]);
      end
    end
  endtask

  task automatic test_back_pressure();
    res_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || rnd_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold: got ready %b ce %0b expected 0000 0", req_ready, rnd_ce); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_data !== 10'h082 || rnd_ce !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL bp_stable[%0d]: got v %0b ch %0d data %h ce %0b ready %b expected 1 1 082 0 0000", c, res_valid, res_ch, res_data, rnd_ce, req_ready);
      end
    end
    res_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 0100", req_ready); end
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_data !== 10'h0C3) begin n_fail++; $display("[TB] FAIL bp_release_result: got v %0b ch %0d data %h expected 1 2 0c3", res_valid, res_ch, res_data); end
  endtask

  task automatic test_drain();
    res_ready = 1'b0; en = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL drain_en_fall: got %b expected 0000", req_ready); end
    tick();
    n_checks++; if (busy !== 1'b1 || res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_enter: got busy %0b v %0b expected 1 1", busy, res_valid); end
    en = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1 || req_ready !== 4'b0000 || res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_en_ignored: got busy %0b ready %b v %0b expected 1 0000 1", busy, req_ready, res_valid); end
    res_ready = 1'b1; en = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL drain_no_grant: got %b expected 0000", req_ready); end
    tick();
    n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_exit: got busy %0b v %0b expected 0 0", busy, res_valid); end
  endtask

  task automatic test_reset_midstream();
    // ptr is 3; granting ch2 alone leaves RES_VALID=1 with ptr=3.
    en = 1'b1; req_valid = 4'b0100; res_ready = 1'b1;
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_ready: got %b expected 0100", req_ready); end
    tick();
    rst = 1'b1; req_valid = 4'b1001; res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_ch !== 2'd2) begin n_fail++; $display("[TB] FAIL mid_pending: got v %0b ch %0d expected 1 2", res_valid, res_ch); end
    #1;
    n_checks++; if (req_ready !== 4'b0000 || rnd_ce !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_gate: got ready %b ce %0b expected 0000 0", req_ready, rnd_ce); end
    tick();
    rst = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL mid_after_rst: got v %0b busy %0b ch %0d expected 0 0 0", res_valid, busy, res_ch); end
    tick();
    res_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", req_ready); end
    tick();
    n_checks++; if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_data !== 10'h041) begin n_fail++; $display("[TB] FAIL mid_result: got v %0b ch %0d data %h expected 1 0 041", res_valid, res_ch, res_data); end
  endtask

  // Run all scenarios in sequence; each leaves the DUT in the state the next one expects.
  initial begin
    test_reset();
    test_single();
    test_negative();
    test_round_robin();
    test_back_pressure();
    test_drain();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
